// File: rtl/async_fifo_rd_pkg.sv
// Shared types and constants for the async FIFO burst reader.
package async_fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rd_state_e;

    localparam int STAT_W    = 32;
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

endpackage

// File: rtl/async_fifo_burst_reader_if.sv
// Command, FIFO read port and output stream of the burst reader.
// master = the reader, slave = its environment.
interface async_fifo_burst_reader_if #(
    parameter int DSIZE = 32,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic             done;

    modport master (
        input  cmd_valid, cmd_len, rdata, rempty, m_ready,
        output cmd_ready, rinc, m_valid, m_data, m_last, done
    );

    modport slave (
        output cmd_valid, cmd_len, rdata, rempty, m_ready,
        input  cmd_ready, rinc, m_valid, m_data, m_last, done
    );
endinterface

// File: rtl/async_fifo_skid2.sv
// Two-entry in-order buffer of {last, data} words with occupancy count.
module async_fifo_skid2
    import async_fifo_rd_pkg::*;
#(
    parameter int W = 33
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic [OCC_W-1:0] occ_o
);
    logic [W-1:0]     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i && (occ_q != '0);
    assign push_ok = push_i && ((occ_q != OCC_W'(BUF_DEPTH)) || pop_ok);

    always_comb begin
        // NOTE: default first so every path assigns occ_d; a missing branch would infer a latch.
        occ_d = occ_q;
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_ok && !push_ok) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            // NOTE: non-blocking (<=) for registered state so every flop samples pre-edge values.
            // NOTE: storage is cleared as well so the head word reads 0 out of reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_d;
        end
    end

    assign dout_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/async_fifo_burst_reader.sv
// Pops a commanded number of words from the async FIFO read port and streams them out.
// Define BURST_READER_STATS_EN to add the stat_words / stat_stall counters.
module async_fifo_burst_reader
    import async_fifo_rd_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int LEN_W = 8,
    parameter int RLAT  = 1
) (
    input  logic                      rclk,
    input  logic                      rrst,
    async_fifo_burst_reader_if.master bus
`ifdef BURST_READER_STATS_EN
    ,
    output logic [STAT_W-1:0]         stat_words,
    output logic [STAT_W-1:0]         stat_stall
`endif
);
    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] issued_nxt;
    logic             done_q, done_d;

    logic             rinc;
    logic             pop;
    logic             push;
    logic             inflight;
    logic             last_word;
    logic [DSIZE:0]   push_entry;
    logic [DSIZE:0]   head_entry;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   budget;

    assign pop        = bus.m_valid && bus.m_ready;
    assign issued_nxt = issued_q + LEN_W'(1);
    assign last_word  = (issued_nxt == len_q);

    // Words held or already on their way into the buffer after this cycle's pop.
    assign budget = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);
    assign rinc   = (state_q == FETCH) && !bus.rempty && (issued_q < len_q)
                    && (budget < (OCC_W+1)'(BUF_DEPTH));

    if (RLAT == 0) begin : g_rlat0
        assign inflight   = 1'b0;
        assign push       = rinc;
        assign push_entry = {last_word, bus.rdata};
    end else begin : g_rlat1
        logic inflight_q;
        logic inflight_last_q;

        always_ff @(posedge rclk) begin
            if (rrst) begin
                inflight_q      <= 1'b0;
                inflight_last_q <= 1'b0;
            end else begin
                inflight_q      <= rinc;
                inflight_last_q <= rinc && last_word;
            end
        end

        assign inflight   = inflight_q;
        assign push       = inflight_q;
        assign push_entry = {inflight_last_q, bus.rdata};
    end

    async_fifo_skid2 #(
        .W (DSIZE + 1)
    ) u_skid (
        .rclk   (rclk),
        .rrst   (rrst),
        .push_i (push),
        .din_i  (push_entry),
        .pop_i  (pop),
        .dout_o (head_entry),
        .occ_o  (occ)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    len_d    = bus.cmd_len;
                    issued_d = '0;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (rinc) begin
                    issued_d = issued_nxt;
                    if (last_word) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_entry[DSIZE]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            done_q   <= done_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rinc      = rinc;
    assign bus.m_valid   = (occ != '0);
    assign bus.m_data    = head_entry[DSIZE-1:0];
    assign bus.m_last    = bus.m_valid && head_entry[DSIZE];
    assign bus.done      = done_q;

`ifdef BURST_READER_STATS_EN
    logic [STAT_W-1:0] stat_words_q;
    logic [STAT_W-1:0] stat_stall_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (pop) begin
                stat_words_q <= stat_words_q + STAT_W'(1);
            end
            if ((state_q == FETCH) && bus.rempty && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + STAT_W'(1);
            end
        end
    end

    assign stat_words = stat_words_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_async_fifo_burst_reader.sv
// Self-checking bench for async_fifo_burst_reader (RLAT=1) with a queue-based FIFO model.
module tb_async_fifo_burst_reader;
    localparam int DSIZE = 32;
    localparam int LEN_W = 8;

    logic rclk = 1'b0;
    logic rrst;

    initial forever #5 rclk = ~rclk;

    async_fifo_burst_reader_if #(.DSIZE(DSIZE), .LEN_W(LEN_W)) bus ();

`ifdef BURST_READER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_stall;
`endif

    async_fifo_burst_reader #(
        .DSIZE (DSIZE),
        .LEN_W (LEN_W),
        .RLAT  (1)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .bus        (bus)
`ifdef BURST_READER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    typedef struct {
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        int len;
        int mode;
        int base;
        int exp_rinc;
        int exp_beats;
        int exp_done;
    } vec_t;

    logic [DSIZE-1:0] fifo_q [$];
    beat_t            exp_q  [$];
    vec_t             vecs   [5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int rinc_cnt, beat_cnt, done_cnt;
    int first_rinc_cyc, first_beat_cyc, last_beat_cyc, done_cyc;

    logic             s_rinc, s_pop, s_mvalid, s_cmd_ready, s_done, s_last, s_rempty;
    logic [DSIZE-1:0] s_data;
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_data;
    logic             prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        rinc_cnt       = 0;
        beat_cnt       = 0;
        done_cnt       = 0;
        first_rinc_cyc = -1;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        done_cyc       = -1;
    endtask

    task automatic push_word(input logic [DSIZE-1:0] d, input logic l);
        fifo_q.push_back(d);
        exp_q.push_back('{data: d, last: l});
        bus.rempty = 1'b0;
    endtask

    // One clock cycle: inputs are already driven; sample, score, then advance the FIFO model.
    task automatic tick();
        beat_t e;
        #1;
        s_rinc      = bus.rinc;
        s_mvalid    = bus.m_valid;
        s_pop       = bus.m_valid && bus.m_ready;
        s_data      = bus.m_data;
        s_last      = bus.m_last;
        s_done      = bus.done;
        s_cmd_ready = bus.cmd_ready;
        s_rempty    = bus.rempty;

        if (!rrst) begin
            check("rinc_while_empty", s_rinc && s_rempty, 0);
            check("occ_gate", s_rinc && ((out_cnt - int'(s_pop)) >= 2), 0);
            check("occ_max", out_cnt <= 2, 1);
            if (prev_stall) begin
                check("hold_valid", s_mvalid, 1);
                check("hold_data", s_data, prev_data);
                check("hold_last", s_last, prev_last);
            end
            if (s_pop) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", s_data, e.data);
                    check("beat_last", s_last, e.last);
                end
                beat_cnt++;
                last_beat_cyc = cyc;
                if (beat_cnt == 1) first_beat_cyc = cyc;
            end
            if (s_rinc) begin
                rinc_cnt++;
                if (rinc_cnt == 1) first_rinc_cyc = cyc;
            end
            if (s_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end

        prev_stall = !rrst && s_mvalid && !bus.m_ready;
        prev_data  = s_data;
        prev_last  = s_last;
        out_cnt    = rrst ? 0 : out_cnt + int'(s_rinc) - int'(s_pop);

        @(posedge rclk);
        #1;
        if (s_rinc && fifo_q.size() != 0) bus.rdata = fifo_q.pop_front();
        bus.rempty = (fifo_q.size() == 0);
        cyc++;
        @(negedge rclk);
    endtask

    function automatic logic ready_for(input int mode, input int n);
        case (mode)
            1:       return (n % 2) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_burst(input vec_t v);
        int accept_cyc;
        clear_counts();
        for (int i = 0; i < v.len; i++) push_word(DSIZE'(v.base + i), i == v.len - 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(v.len);
        bus.m_ready   = 1'b1;
        accept_cyc    = cyc;
        tick();
        check("cmd_ready_at_accept", s_cmd_ready, 1);
        bus.cmd_valid = 1'b0;
        for (int n = 0; n < 400 && !(beat_cnt == v.len && done_cnt != 0); n++) begin
            bus.m_ready = ready_for(v.mode, n);
            tick();
        end
        bus.m_ready = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        check("burst_beats", beat_cnt, v.exp_beats);
        check("burst_rinc", rinc_cnt, v.exp_rinc);
        check("burst_done", done_cnt, v.exp_done);
        check("sb_drained", exp_q.size(), 0);
        check("cmd_ready_after", s_cmd_ready, 1);
        if (v.len == 0) begin
            check("zero_done_cyc", done_cyc, accept_cyc + 1);
        end else begin
            check("first_rinc_cyc", first_rinc_cyc, accept_cyc + 1);
            check("done_after_last", done_cyc, last_beat_cyc + 1);
            if (v.mode == 0) check("first_beat_cyc", first_beat_cyc, accept_cyc + 3);
        end
    endtask

    initial begin
        vecs[0] = '{4,  0, 'hA,   4,  4,  1};
        vecs[1] = '{16, 1, 0,     16, 16, 1};
        vecs[2] = '{1,  0, 'h55,  1,  1,  1};
        vecs[3] = '{0,  0, 0,     0,  0,  1};
        vecs[4] = '{7,  2, 'h200, 7,  7,  1};

        rrst          = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.rdata     = '0;
        bus.rempty    = 1'b1;
        bus.m_ready   = 1'b0;
        clear_counts();

        for (int i = 0; i < 5; i++) tick();
        rrst = 1'b0;
        tick();
        check("rst_cmd_ready", s_cmd_ready, 1);
        check("rst_m_valid", s_mvalid, 0);
        check("rst_rinc", s_rinc, 0);
        check("rst_done", s_done, 0);
        check("rst_m_data", s_data, 0);
        check("rst_m_last", s_last, 0);

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // FIFO empty when the command arrives; data shows up 100 ns later.
        clear_counts();
        bus.m_ready   = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(3);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("stall_no_rinc", rinc_cnt, 0);
        check("stall_no_beat", beat_cnt, 0);
        push_word(DSIZE'(100), 1'b0);
        push_word(DSIZE'(101), 1'b0);
        push_word(DSIZE'(102), 1'b1);
        for (int n = 0; n < 50 && !(beat_cnt == 3 && done_cnt != 0); n++) tick();
        check("stall_beats", beat_cnt, 3);
        check("stall_rinc", rinc_cnt, 3);
        check("stall_done", done_cnt, 1);
        check("stall_sb_drained", exp_q.size(), 0);

        // Reset after the second beat of an 8-word burst.
        clear_counts();
        for (int i = 0; i < 8; i++) push_word(DSIZE'('h300 + i), i == 7);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(8);
        tick();
        bus.cmd_valid = 1'b0;
        for (int n = 0; n < 50 && beat_cnt < 2; n++) tick();
        check("mid_two_beats", beat_cnt, 2);
        bus.m_ready = 1'b0;
        rrst        = 1'b1;
        tick();
        rrst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        bus.rempty = 1'b1;
        clear_counts();
        tick();
        check("mid_m_valid", s_mvalid, 0);
        check("mid_rinc", s_rinc, 0);
        check("mid_cmd_ready", s_cmd_ready, 1);
        check("mid_done", s_done, 0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mid_no_done", done_cnt, 0);
        check("mid_no_beat", beat_cnt, 0);
        run_burst('{5, 0, 'h400, 5, 5, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
